// File: rtl/tt_sub_pkg.sv
// rtl/tt_sub_pkg.sv - shared widths, FSM encoding and uio bit indices for the serial subtractor
package tt_sub_pkg;

   localparam int SUB_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // uio_in control pins
   localparam int UIO_LOAD_A = 0;
   localparam int UIO_LOAD_B = 1;
   localparam int UIO_START  = 2;

   // uio_out status pins
   localparam int UIO_BUSY   = 4;
   localparam int UIO_DONE   = 5;
   localparam int UIO_BORROW = 6;
   localparam int UIO_OVF    = 7;

   // upper nibble of uio is output, lower nibble is input
   localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/tt_um_subtractor_serial_ss_if.sv
// rtl/tt_um_subtractor_serial_ss_if.sv - pin bundle for the serial subtractor tile
interface tt_sub_if;

   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   // driver side: owns the inputs of the tile
   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   // tile side
   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );

endinterface

// File: rtl/tt_sync_edge.sv
// rtl/tt_sync_edge.sv - 2-flop synchronizer plus rising-edge detector, vectored
module tt_sync_edge #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_ena,
   input  logic [N-1:0] i_pin,
   output logic [N-1:0] o_rise
);

   logic [N-1:0] r_meta;
   logic [N-1:0] r_sync;
   logic [N-1:0] r_prev;

   // synchronizer chain and edge history; frozen while the tile is disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
         r_prev <= '0;
      end else if (i_ena) begin
         r_meta <= i_pin;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/tt_um_subtractor_serial_ss.sv
// rtl/tt_um_subtractor_serial_ss.sv - bit-serial A-B subtractor with borrow and signed overflow flags
module tt_um_subtractor_serial_ss
   import tt_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_part;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bw;
   logic [7:0]       r_uo;
   logic             r_busy;
   logic             r_done;
   logic             r_borrow;
   logic             r_ovf;

   logic [2:0]       w_rise;
   logic             w_accept;
   logic             w_ld_a;
   logic             w_ld_b;
   logic             w_go;
   logic             w_last;
   logic [WIDTH-1:0] w_a_src;
   logic [WIDTH-1:0] w_b_src;
   logic             w_d;
   logic             w_bw_nxt;
   logic [WIDTH-1:0] w_res;
   logic [7:0]       w_uio;
   logic             w_unused;

   assign w_unused = &{1'b0, uio_in[7:3]};

   tt_sync_edge #(.N(3)) u_sync_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_ena  (ena),
      .i_pin  (uio_in[2:0]),
      .o_rise (w_rise)
   );

   // control edges are only honoured outside SHIFT; edges during SHIFT are simply dropped
   assign w_accept = ena && (r_state != ST_SHIFT);
   assign w_ld_a   = w_accept && w_rise[UIO_LOAD_A];
   assign w_ld_b   = w_accept && w_rise[UIO_LOAD_B];
   assign w_go     = w_accept && w_rise[UIO_START];
   assign w_last   = ena && (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);

   // a load coinciding with start feeds the fresh byte straight into the computation
   assign w_a_src  = w_ld_a ? WIDTH'(ui_in) : r_a;
   assign w_b_src  = w_ld_b ? WIDTH'(ui_in) : r_b;

   // one full-subtractor bit slice, LSB first
   assign w_d      = r_sa[0] ^ r_sb[0] ^ r_bw;
   assign w_bw_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_bw);
   assign w_res    = {w_d, r_part[WIDTH-1:1]};

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else if (ena) begin
         r_state <= w_state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE, ST_DONE: if (w_go)   w_state_nxt = ST_SHIFT;
         ST_SHIFT:         if (w_last) w_state_nxt = ST_DONE;
         default:          w_state_nxt = ST_IDLE;
      endcase
   end

   // operands, shift datapath and registered result/flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sa     <= '0;
         r_sb     <= '0;
         r_part   <= '0;
         r_cnt    <= '0;
         r_bw     <= 1'b0;
         r_uo     <= 8'h00;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (ena) begin
         if (w_ld_a) r_a <= w_a_src;
         if (w_ld_b) r_b <= w_b_src;
         if (w_go) begin
            r_sa   <= w_a_src;
            r_sb   <= w_b_src;
            r_part <= '0;
            r_cnt  <= '0;
            r_bw   <= 1'b0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
         end else if (r_state == ST_SHIFT) begin
            r_sa   <= r_sa >> 1;
            r_sb   <= r_sb >> 1;
            r_part <= w_res;
            r_cnt  <= r_cnt + 1'b1;
            r_bw   <= w_bw_nxt;
            if (w_last) begin
               // result and flags change only here, so they stay stable throughout SHIFT
               r_uo     <= 8'(w_res);
               r_borrow <= w_bw_nxt;
               r_ovf    <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d ^ r_a[WIDTH-1]);
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
            end
         end
      end
   end

   // status byte assembly from registered flags
   always_comb begin
      w_uio             = 8'h00;
      w_uio[UIO_BUSY]   = r_busy;
      w_uio[UIO_DONE]   = r_done;
      w_uio[UIO_BORROW] = r_borrow;
      w_uio[UIO_OVF]    = r_ovf;
   end

   assign uo_out  = r_uo;
   assign uio_out = w_uio;
   assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_subtractor_serial_ss.sv
// tb/tb_tt_um_subtractor_serial_ss.sv - directed and random checks of the serial subtractor against an arithmetic model
module tb_tt_um_subtractor_serial_ss;
   import tt_sub_pkg::*;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   tt_sub_if pins ();

   tt_um_subtractor_serial_ss #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (pins.ena),
      .ui_in   (pins.ui_in),
      .uio_in  (pins.uio_in),
      .uo_out  (pins.uo_out),
      .uio_out (pins.uio_out),
      .uio_oe  (pins.uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // reference: plain integer arithmetic on the operand values
   function automatic logic [7:0] ref_diff(input logic [7:0] a, input logic [7:0] b);
      int d;
      d = int'(a) - int'(b);
      if (d < 0) d += 256;
      return 8'(d);
   endfunction

   function automatic logic ref_borrow(input logic [7:0] a, input logic [7:0] b);
      return int'(a) < int'(b);
   endfunction

   function automatic logic ref_ovf(input logic [7:0] a, input logic [7:0] b);
      int sa, sb, sd;
      sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
      sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
      sd = sa - sb;
      return (sd > 127) || (sd < -128);
   endfunction

   // raise the given uio_in bits for one cycle; returns one negedge after the action edge
   task automatic pulse(input logic [7:0] mask);
      @(negedge clk);
      pins.uio_in = mask;
      @(negedge clk);
      pins.uio_in = 8'h00;
      repeat (2) @(negedge clk);
   endtask

   task automatic load(input logic [7:0] val, input int idx);
      pins.ui_in = val;
      pulse(8'(1 << idx));
   endtask

   // start (optionally with coincident loads in mask) and check the result after exactly 8 SHIFT cycles
   task automatic start_and_check(input logic [7:0] mask, input logic [7:0] a,
                                  input logic [7:0] b, input string tag);
      pulse(mask | 8'(1 << UIO_START));
      check({tag, ".busy_on_start"}, 32'(pins.uio_out[UIO_BUSY]), 32'd1);
      repeat (7) @(negedge clk);
      check({tag, ".not_done_at_7"}, 32'(pins.uio_out[UIO_DONE]), 32'd0);
      @(negedge clk);
      check({tag, ".done"},   32'(pins.uio_out[UIO_DONE]),   32'd1);
      check({tag, ".busy"},   32'(pins.uio_out[UIO_BUSY]),   32'd0);
      check({tag, ".result"}, 32'(pins.uo_out),              32'(ref_diff(a, b)));
      check({tag, ".borrow"}, 32'(pins.uio_out[UIO_BORROW]), 32'(ref_borrow(a, b)));
      check({tag, ".ovf"},    32'(pins.uio_out[UIO_OVF]),    32'(ref_ovf(a, b)));
      check({tag, ".low_nib"}, 32'(pins.uio_out[3:0]),       32'd0);
   endtask

   task automatic run(input logic [7:0] a, input logic [7:0] b, input string tag);
      load(a, UIO_LOAD_A);
      load(b, UIO_LOAD_B);
      start_and_check(8'h00, a, b, tag);
   endtask

   initial begin
      logic [7:0] ra, rb, held;
      total = 0;
      bad   = 0;
      pins.ena    = 1'b1;
      pins.ui_in  = 8'h00;
      pins.uio_in = 8'h00;
      rst_n       = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst.uo_out",  32'(pins.uo_out),  32'h00);
      check("rst.uio_out", 32'(pins.uio_out), 32'h00);
      check("rst.uio_oe",  32'(pins.uio_oe),  32'hF0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // directed vectors
      run(8'h50, 8'h20, "d50_20");
      run(8'h20, 8'h50, "d20_50");
      run(8'h80, 8'h01, "d80_01");
      run(8'h9C, 8'h37, "d9C_37");
      check("roundtrip", 32'(8'(pins.uo_out + 8'h37)), 32'h9C);

      // edges during SHIFT are ignored and not queued
      load(8'h50, UIO_LOAD_A);
      load(8'h20, UIO_LOAD_B);
      pulse(8'(1 << UIO_START));
      @(negedge clk);
      pins.ui_in  = 8'hFF;
      pins.uio_in = 8'(1 << UIO_LOAD_A) | 8'(1 << UIO_START);
      @(negedge clk);
      pins.uio_in = 8'h00;
      check("shiftign.busy", 32'(pins.uio_out[UIO_BUSY]), 32'd1);
      repeat (6) @(negedge clk);
      check("shiftign.done",   32'(pins.uio_out[UIO_DONE]), 32'd1);
      check("shiftign.result", 32'(pins.uo_out), 32'(ref_diff(8'h50, 8'h20)));
      repeat (3) @(negedge clk);
      check("shiftign.noqueue", 32'(pins.uio_out[UIO_DONE]), 32'd1);
      pins.ui_in = 8'h00;
      start_and_check(8'h00, 8'h50, 8'h20, "shiftign.rerun");

      // load coinciding with start uses the fresh byte
      pins.ui_in = 8'h10;
      start_and_check(8'(1 << UIO_LOAD_A), 8'h10, 8'h20, "coincide");

      // edges while ena=0 are lost
      held = ref_diff(8'h10, 8'h20);
      @(negedge clk);
      pins.ena    = 1'b0;
      pins.uio_in = 8'(1 << UIO_START);
      repeat (3) @(negedge clk);
      pins.uio_in = 8'h00;
      repeat (2) @(negedge clk);
      pins.ena = 1'b1;
      repeat (5) @(negedge clk);
      check("ena0.busy",   32'(pins.uio_out[UIO_BUSY]), 32'd0);
      check("ena0.done",   32'(pins.uio_out[UIO_DONE]), 32'd1);
      check("ena0.result", 32'(pins.uo_out), 32'(held));

      // asynchronous reset in the middle of SHIFT
      load(8'h9C, UIO_LOAD_A);
      load(8'h37, UIO_LOAD_B);
      pulse(8'(1 << UIO_START));
      repeat (4) @(negedge clk);
      check("midrst.busy_before", 32'(pins.uio_out[UIO_BUSY]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.uo_out",  32'(pins.uo_out),  32'h00);
      check("midrst.uio_out", 32'(pins.uio_out), 32'h00);
      check("midrst.uio_oe",  32'(pins.uio_oe),  32'hF0);
      check("midrst.state",   32'(dut.r_state),  32'(ST_IDLE));
      check("midrst.busy",    32'(pins.uio_out[UIO_BUSY]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("postrst.uo_out", 32'(pins.uo_out),  32'h00);
      check("postrst.uio",    32'(pins.uio_out), 32'h00);
      start_and_check(8'h00, 8'h00, 8'h00, "postrst.zero");

      // randomized operands
      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run(ra, rb, $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
